dm_store_buffer: RTL and testbench

- Data-memory bridge that sits between the core's data-memory port (addr, store data, byte mask, write request) and a data bus with a req/ack handshake.
- Stores are posted into a DEPTH-entry FIFO and drained in order, one bus transaction at a time.
- Loads first drain the FIFO, then issue a single read; the core is stalled until the load data is valid.
- Strict program order is preserved: every buffered store reaches the bus before any later load.

---
 rtl/dm_sb_pkg.sv | 39 +++
 rtl/dm_store_buffer_sb_fifo.sv | 63 ++++++
 rtl/dm_store_buffer.sv | 168 ++++++++++++++++
 tb/tb_dm_store_buffer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_sb_pkg.sv
// Shared types for the data-memory store buffer: FSM states, FIFO entry layout, lane merge helper.
// The entry widths here set the default ADDR_W/DATA_W of dm_store_buffer; keep them in step.
package dm_sb_pkg;

    localparam int LANES     = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RD_WAIT = 2'd2,
        RD_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [SB_ADDR_W-3:0] word_addr;
        logic [SB_DATA_W-1:0] data;
        logic [LANES-1:0]     mask;
    } sb_entry_t;

    // Overlay the enabled byte lanes of a new store onto an existing entry.
    function automatic sb_entry_t coalesce_entry(
        input sb_entry_t            old_e,
        input logic [SB_DATA_W-1:0] data,
        input logic [LANES-1:0]     mask
    );
        sb_entry_t m;
        m = old_e;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                m.data[8*i +: 8] = data[8*i +: 8];
            end
        end
        m.mask = old_e.mask | mask;
        return m;
    endfunction

endpackage

// File: rtl/dm_store_buffer_sb_fifo.sv
// DEPTH-entry in-order store FIFO with a combinational head read and an in-place
// tail rewrite port used when a new store merges into the newest entry.
module sb_fifo
    import dm_sb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  sb_entry_t                  push_entry,
    input  logic                       pop,
    input  logic                       merge,
    input  sb_entry_t                  merge_entry,
    output sb_entry_t                  head_entry,
    output sb_entry_t                  tail_entry,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    sb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] tail_idx;

    // tail_ptr points at the next free slot; the newest entry sits one behind it.
    assign tail_idx   = tail_ptr - PTR_W'(1);
    assign head_entry = mem[head_ptr];
    assign tail_entry = mem[tail_idx];
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                mem[tail_ptr] <= push_entry;
                tail_ptr      <= tail_ptr + PTR_W'(1);
            end else if (merge) begin
                mem[tail_idx] <= merge_entry;
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-store bridge between the core data port and a req/ack data bus; loads drain the
// buffer first. Optional store coalescing into the newest entry: define SB_COALESCE_EN.
module dm_store_buffer
    import dm_sb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [ADDR_W-1:0]          core_addr_in,
    input  logic [DATA_W-1:0]          core_wdata_in,
    input  logic [LANES-1:0]           core_wr_mask_in,
    input  logic                       core_wr_req_in,
    input  logic                       core_rd_req_in,
    output logic [DATA_W-1:0]          core_rdata_out,
    output logic                       core_stall_out,
    output logic                       bus_req_out,
    output logic                       bus_we_out,
    output logic [ADDR_W-1:0]          bus_addr_out,
    output logic [DATA_W-1:0]          bus_wdata_out,
    output logic [LANES-1:0]           bus_mask_out,
    input  logic                       bus_ack_in,
    input  logic [DATA_W-1:0]          bus_rdata_in,
    output state_t                     dbg_state,
    output logic [$clog2(DEPTH+1)-1:0] dbg_count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-3:0] rd_word_q;
    logic [DATA_W-1:0] rdata_q;

    sb_entry_t         head_entry;
    sb_entry_t         tail_entry;
    sb_entry_t         push_entry;
    sb_entry_t         merged_entry;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;

    logic              write_active;
    logic              read_active;
    logic              pop;
    logic              push;
    logic              merge;
    logic              store_req;
    logic              store_blocked;
    logic              load_start;
    logic              last_pop;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^core_addr_in[1:0];

    // Bus handshake: bus_req_out rises with all bus_* fields valid and they hold steady until
    // the cycle bus_ack_in is high; that edge completes the transfer. Ack without req is ignored.
    assign write_active = ((state == IDLE) || (state == DRAIN)) && !empty;
    assign read_active  = (state == RD_WAIT);
    assign pop          = write_active && bus_ack_in;
    assign last_pop     = pop && (count == CNT_W'(1));

    // Zero-mask stores are accepted (no stall) but never enter the buffer.
    assign store_req  = (state == IDLE) && core_wr_req_in && (core_wr_mask_in != '0);
    assign load_start = (state == IDLE) && core_rd_req_in && !core_wr_req_in;

    assign push_entry = '{word_addr: core_addr_in[ADDR_W-1:2],
                          data:      core_wdata_in,
                          mask:      core_wr_mask_in};

`ifdef SB_COALESCE_EN
    // A lone entry already on the bus must not change under the transaction.
    assign merge = store_req && !empty
                   && (tail_entry.word_addr == core_addr_in[ADDR_W-1:2])
                   && !((count == CNT_W'(1)) && write_active);
    assign merged_entry = coalesce_entry(tail_entry, core_wdata_in, core_wr_mask_in);
`else
    logic unused_tail;
    assign merge        = 1'b0;
    assign merged_entry = '0;
    assign unused_tail  = ^tail_entry;
`endif

    assign store_blocked = store_req && !merge && full && !pop;
    assign push          = store_req && !merge && !store_blocked;

    sb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk_in),
        .rst_n      (rst_in),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .merge      (merge),
        .merge_entry(merged_entry),
        .head_entry (head_entry),
        .tail_entry (tail_entry),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            rd_word_q <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            if (load_start) begin
                rd_word_q <= core_addr_in[ADDR_W-1:2];
            end
            if (read_active && bus_ack_in) begin
                rdata_q <= bus_rdata_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = (empty || last_pop) ? RD_WAIT : DRAIN;
                end
            end
            DRAIN: begin
                if (empty || last_pop) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus_ack_in) begin
                    state_nxt = RD_DONE;
                end
            end
            RD_DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus_req_out   = 1'b0;
        bus_we_out    = 1'b0;
        bus_addr_out  = '0;
        bus_wdata_out = '0;
        bus_mask_out  = '0;
        if (write_active) begin
            bus_req_out   = 1'b1;
            bus_we_out    = 1'b1;
            bus_addr_out  = {head_entry.word_addr, 2'b00};
            bus_wdata_out = head_entry.data;
            bus_mask_out  = head_entry.mask;
        end else if (read_active) begin
            bus_req_out  = 1'b1;
            bus_addr_out = {rd_word_q, 2'b00};
        end
    end

    assign core_stall_out = (core_rd_req_in && (state != RD_DONE)) || store_blocked;
    assign core_rdata_out = rdata_q;
    assign dbg_state      = state;
    assign dbg_count      = count;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer: stores, full-buffer stall, ordered load, reset, coalescing.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_dm_store_buffer;
    import dm_sb_pkg::*;

    localparam int TXN_W = 1 + 32 + 32 + 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] core_addr_in;
    logic [31:0] core_wdata_in;
    logic [3:0]  core_wr_mask_in;
    logic        core_wr_req_in;
    logic        core_rd_req_in;
    logic [31:0] core_rdata_out;
    logic        core_stall_out;
    logic        bus_req_out;
    logic        bus_we_out;
    logic [31:0] bus_addr_out;
    logic [31:0] bus_wdata_out;
    logic [3:0]  bus_mask_out;
    logic        bus_ack_in;
    logic [31:0] bus_rdata_in;
    state_t      dbg_state;
    logic [2:0]  dbg_count;

    int checks = 0;
    int errors = 0;
    int n_stall;

    logic [TXN_W-1:0] exp_q[$];
    logic [TXN_W-1:0] obs_q[$];

    dm_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .core_addr_in   (core_addr_in),
        .core_wdata_in  (core_wdata_in),
        .core_wr_mask_in(core_wr_mask_in),
        .core_wr_req_in (core_wr_req_in),
        .core_rd_req_in (core_rd_req_in),
        .core_rdata_out (core_rdata_out),
        .core_stall_out (core_stall_out),
        .bus_req_out    (bus_req_out),
        .bus_we_out     (bus_we_out),
        .bus_addr_out   (bus_addr_out),
        .bus_wdata_out  (bus_wdata_out),
        .bus_mask_out   (bus_mask_out),
        .bus_ack_in     (bus_ack_in),
        .bus_rdata_in   (bus_rdata_in),
        .dbg_state      (dbg_state),
        .dbg_count      (dbg_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog sim time expired");
        $fatal(1, "watchdog");
    end

    // Record every completed bus transaction: {we, addr, write data or read data, mask}.
    always @(posedge clk_in) begin
        if (rst_in && bus_req_out && bus_ack_in) begin
            obs_q.push_back({bus_we_out, bus_addr_out,
                             bus_we_out ? bus_wdata_out : bus_rdata_in, bus_mask_out});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        core_addr_in    = a;
        core_wdata_in   = d;
        core_wr_mask_in = m;
        core_wr_req_in  = 1'b1;
    endtask

    task automatic idle_core();
        core_wr_req_in  = 1'b0;
        core_rd_req_in  = 1'b0;
        core_wr_mask_in = 4'b0000;
    endtask

    task automatic drain_all();
        bus_ack_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (dbg_count == 3'd0) break;
            tick();
        end
        bus_ack_in = 1'b0;
    endtask

    task automatic compare_txns(input string tag);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_txn_count got %0d exp %0d", tag, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_txn%0d got %h exp %h", tag, i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk_in);
        checks++; if (bus_req_out !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %b exp 0", bus_req_out); end
        checks++; if (bus_we_out !== 1'b0) begin errors++; $display("FAIL reset_bus_we got %b exp 0", bus_we_out); end
        checks++; if (bus_addr_out !== 32'h0) begin errors++; $display("FAIL reset_bus_addr got %h exp 0", bus_addr_out); end
        checks++; if (bus_mask_out !== 4'h0) begin errors++; $display("FAIL reset_bus_mask got %b exp 0", bus_mask_out); end
        checks++; if (core_stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", core_stall_out); end
        checks++; if (core_rdata_out !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", core_rdata_out); end
        checks++; if (dbg_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", dbg_count); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        tick();
        rst_in = 1'b1;
        tick();
    endtask

    task automatic test_single_store();
        drive_store(32'h0000_1006, 32'hAABB_0000, 4'b1100);
        exp_q.push_back({1'b1, 32'h0000_1004, 32'hAABB_0000, 4'b1100});
        @(negedge clk_in);
        checks++; if (core_stall_out !== 1'b0) begin errors++; $display("FAIL single_stall got %b exp 0", core_stall_out); end
        checks++; if (bus_req_out !== 1'b0) begin errors++; $display("FAIL single_req_early got %b exp 0", bus_req_out); end
        tick();
        idle_core();
        @(negedge clk_in);
        checks++; if (bus_req_out !== 1'b1 || bus_we_out !== 1'b1) begin errors++; $display("FAIL single_req got %b%b exp 11", bus_req_out, bus_we_out); end
        checks++; if (bus_addr_out !== 32'h0000_1004) begin errors++; $display("FAIL single_addr got %h exp 00001004", bus_addr_out); end
        checks++; if (bus_mask_out !== 4'b1100) begin errors++; $display("FAIL single_mask got %b exp 1100", bus_mask_out); end
        checks++; if (bus_wdata_out !== 32'hAABB_0000) begin errors++; $display("FAIL single_wdata got %h exp aabb0000", bus_wdata_out); end
        checks++; if (dbg_count !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d exp 1", dbg_count); end
        tick();
        @(negedge clk_in);
        checks++; if (bus_req_out !== 1'b1) begin errors++; $display("FAIL single_req_hold got %b exp 1", bus_req_out); end
        tick();
        bus_ack_in = 1'b1;
        @(negedge clk_in);
        checks++; if (bus_addr_out !== 32'h0000_1004) begin errors++; $display("FAIL single_addr_stable got %h exp 00001004", bus_addr_out); end
        tick();
        bus_ack_in = 1'b0;
        @(negedge clk_in);
        checks++; if (bus_req_out !== 1'b0) begin errors++; $display("FAIL single_req_after got %b exp 0", bus_req_out); end
        checks++; if (dbg_count !== 3'd0) begin errors++; $display("FAIL single_count0 got %0d exp 0", dbg_count); end
        compare_txns("single");
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({1'b1, 32'h100 + 32'(4*i), 32'h1111_1111 * 32'(i+1), 4'hF});
        end
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h100 + 32'(4*i), 32'h1111_1111 * 32'(i+1), 4'hF);
            @(negedge clk_in);
            checks++; if (core_stall_out !== 1'b0) begin errors++; $display("FAIL b2b_stall%0d got %b exp 0", i, core_stall_out); end
            tick();
        end
        drive_store(32'h110, 32'h5555_5555, 4'hF);
        @(negedge clk_in);
        checks++; if (core_stall_out !== 1'b1) begin errors++; $display("FAIL b2b_full_stall got %b exp 1", core_stall_out); end
        checks++; if (dbg_count !== 3'd4) begin errors++; $display("FAIL b2b_full_count got %0d exp 4", dbg_count); end
        tick();
        @(negedge clk_in);
        checks++; if (core_stall_out !== 1'b1 || dbg_count !== 3'd4) begin errors++; $display("FAIL b2b_still_full got stall=%b count=%0d exp stall=1 count=4", core_stall_out, dbg_count); end
        checks++; if (bus_addr_out !== 32'h100) begin errors++; $display("FAIL b2b_head_addr got %h exp 00000100", bus_addr_out); end
        tick();
        bus_ack_in = 1'b1;
        @(negedge clk_in);
        checks++; if (core_stall_out !== 1'b0) begin errors++; $display("FAIL b2b_pop_release got %b exp 0", core_stall_out); end
        tick();
        idle_core();
        @(negedge clk_in);
        checks++; if (dbg_count !== 3'd4) begin errors++; $display("FAIL b2b_push_pop_count got %0d exp 4", dbg_count); end
        checks++; if (bus_addr_out !== 32'h104) begin errors++; $display("FAIL b2b_next_addr got %h exp 00000104", bus_addr_out); end
        tick();
        drain_all();
        checks++; if (dbg_count !== 3'd0) begin errors++; $display("FAIL b2b_drain got %0d exp 0", dbg_count); end
        compare_txns("b2b");
        tick();
    endtask

    task automatic test_load_after_stores();
        exp_q.push_back({1'b1, 32'h500, 32'hA0A0_A0A0, 4'b1111});
        exp_q.push_back({1'b1, 32'h504, 32'hB0B0_B0B0, 4'b0011});
        exp_q.push_back({1'b0, 32'h2000, 32'h1234_5678, 4'b0000});
        drive_store(32'h500, 32'hA0A0_A0A0, 4'b1111);
        tick();
        drive_store(32'h504, 32'hB0B0_B0B0, 4'b0011);
        tick();
        idle_core();
        core_addr_in   = 32'h2000;
        core_rd_req_in = 1'b1;
        bus_ack_in     = 1'b1;
        bus_rdata_in   = 32'h1234_5678;
        n_stall = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (!core_stall_out) break;
            n_stall++;
            tick();
        end
        checks++; if (core_stall_out !== 1'b0) begin errors++; $display("FAIL ld_st_release got %b exp 0", core_stall_out); end
        checks++; if (n_stall !== 3) begin errors++; $display("FAIL ld_st_stall_cycles got %0d exp 3", n_stall); end
        checks++; if (dbg_state !== RD_DONE) begin errors++; $display("FAIL ld_st_state got %0d exp 3", dbg_state); end
        checks++; if (core_rdata_out !== 32'h1234_5678) begin errors++; $display("FAIL ld_st_rdata got %h exp 12345678", core_rdata_out); end
        tick();
        idle_core();
        bus_ack_in = 1'b0;
        @(negedge clk_in);
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL ld_st_idle got %0d exp 0", dbg_state); end
        compare_txns("ld_st");
        tick();
    endtask

    task automatic test_load_empty();
        core_addr_in   = 32'h2004;
        core_rd_req_in = 1'b1;
        bus_ack_in     = 1'b1;
        bus_rdata_in   = 32'hCAFE_F00D;
        @(negedge clk_in);
        checks++; if (core_stall_out !== 1'b1 || bus_req_out !== 1'b0) begin errors++; $display("FAIL ld_c0 got stall=%b req=%b exp stall=1 req=0", core_stall_out, bus_req_out); end
        tick();
        @(negedge clk_in);
        checks++; if (core_stall_out !== 1'b1) begin errors++; $display("FAIL ld_c1_stall got %b exp 1", core_stall_out); end
        checks++; if (bus_req_out !== 1'b1 || bus_we_out !== 1'b0 || bus_mask_out !== 4'b0000) begin errors++; $display("FAIL ld_c1_bus got req=%b we=%b mask=%b exp 1 0 0000", bus_req_out, bus_we_out, bus_mask_out); end
        checks++; if (bus_addr_out !== 32'h2004) begin errors++; $display("FAIL ld_c1_addr got %h exp 00002004", bus_addr_out); end
        tick();
        @(negedge clk_in);
        checks++; if (core_stall_out !== 1'b0) begin errors++; $display("FAIL ld_c2_stall got %b exp 0", core_stall_out); end
        checks++; if (core_rdata_out !== 32'hCAFE_F00D) begin errors++; $display("FAIL ld_c2_rdata got %h exp cafef00d", core_rdata_out); end
        tick();
        idle_core();
        bus_ack_in = 1'b0;
        @(negedge clk_in);
        checks++; if (dbg_state !== IDLE || bus_req_out !== 1'b0) begin errors++; $display("FAIL ld_c3 got state=%0d req=%b exp 0 0", dbg_state, bus_req_out); end
        obs_q.delete();
        tick();
    endtask

    task automatic test_zero_mask();
        drive_store(32'h600, 32'hFFFF_FFFF, 4'b0000);
        @(negedge clk_in);
        checks++; if (core_stall_out !== 1'b0) begin errors++; $display("FAIL zmask_stall got %b exp 0", core_stall_out); end
        tick();
        idle_core();
        @(negedge clk_in);
        checks++; if (dbg_count !== 3'd0 || bus_req_out !== 1'b0) begin errors++; $display("FAIL zmask_discard got count=%0d req=%b exp 0 0", dbg_count, bus_req_out); end
        tick();
    endtask

    task automatic test_reset_mid_load();
        drive_store(32'h700, 32'h7777_0000, 4'b1100);
        tick();
        drive_store(32'h704, 32'h0000_7777, 4'b0011);
        tick();
        idle_core();
        core_addr_in   = 32'h2008;
        core_rd_req_in = 1'b1;
        tick();
        @(negedge clk_in);
        checks++; if (dbg_state !== DRAIN || dbg_count !== 3'd2 || bus_req_out !== 1'b1) begin errors++; $display("FAIL rstmid_pre got state=%0d count=%0d req=%b exp 1 2 1", dbg_state, dbg_count, bus_req_out); end
        #1 rst_in = 1'b0;
        #1;
        checks++; if (bus_req_out !== 1'b0) begin errors++; $display("FAIL rstmid_req got %b exp 0", bus_req_out); end
        checks++; if (dbg_count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", dbg_count); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rstmid_state got %0d exp 0", dbg_state); end
        checks++; if (core_rdata_out !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got %h exp 0", core_rdata_out); end
        idle_core();
        tick();
        rst_in = 1'b1;
        tick();
        obs_q.delete();
    endtask

    task automatic test_coalesce();
        exp_q.push_back({1'b1, 32'h4000, 32'hDEAD_BEEF, 4'b1111});
`ifdef SB_COALESCE_EN
        exp_q.push_back({1'b1, 32'h3000, 32'h0033_0011, 4'b0101});
`else
        exp_q.push_back({1'b1, 32'h3000, 32'h0000_0011, 4'b0001});
        exp_q.push_back({1'b1, 32'h3000, 32'h0033_0000, 4'b0100});
`endif
        drive_store(32'h4000, 32'hDEAD_BEEF, 4'b1111);
        tick();
        drive_store(32'h3000, 32'h0000_0011, 4'b0001);
        tick();
        drive_store(32'h3000, 32'h0033_0000, 4'b0100);
        tick();
        idle_core();
        @(negedge clk_in);
`ifdef SB_COALESCE_EN
        checks++; if (dbg_count !== 3'd2) begin errors++; $display("FAIL coal_count got %0d exp 2", dbg_count); end
`else
        checks++; if (dbg_count !== 3'd3) begin errors++; $display("FAIL coal_count got %0d exp 3", dbg_count); end
`endif
        tick();
        drain_all();
        checks++; if (dbg_count !== 3'd0) begin errors++; $display("FAIL coal_drain got %0d exp 0", dbg_count); end
        compare_txns("coal");
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_in          = 1'b0;
        core_addr_in    = '0;
        core_wdata_in   = '0;
        core_wr_mask_in = '0;
        core_wr_req_in  = 1'b0;
        core_rd_req_in  = 1'b0;
        bus_ack_in      = 1'b0;
        bus_rdata_in    = '0;
        test_reset();
        test_single_store();
        test_back_to_back();
        test_load_after_stores();
        test_load_empty();
        test_zero_mask();
        test_reset_mid_load();
        test_coalesce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
